// File: rtl/freq_meas_ctrl.sv
// Frequency-counter measurement sequencer: gates a synchronized input edge counter,
// hands the latched count to a BCD converter, holds the result, then re-arms or stops.
module freq_meas_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MAX_COUNT   = 999_999,
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal_in,
    input  logic             run,
    input  logic             single,
    input  logic [1:0]       gate_sel,
    input  logic             bcd_done,
    output logic             bcd_start,
    output logic [CNT_W-1:0] count_out,
    output logic [1:0]       gate_tag,
    output logic             overflow,
    output logic             valid,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_GATE, S_LATCH, S_CONV, S_HOLD
    } state_t;

    localparam logic [31:0] GATE_1S    = 32'(CLK_HZ);
    localparam logic [31:0] GATE_100MS = 32'(CLK_HZ / 10);
    localparam logic [31:0] GATE_10MS  = 32'(CLK_HZ / 100);
    localparam logic [31:0] GATE_10S   = 32'(CLK_HZ * 10);
    localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       gate_lat_q, gate_lat_d;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic [1:0]       gate_tag_q, gate_tag_d;
    logic             overflow_q, overflow_d;
    logic             bcd_start_q, bcd_start_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             edge_det;

    function automatic logic [31:0] gate_len(input logic [1:0] sel);
        case (sel)
            2'b00:   return GATE_1S;
            2'b01:   return GATE_100MS;
            2'b10:   return GATE_10MS;
            default: return GATE_10S;
        endcase
    endfunction

    assign edge_det = sync2_q & ~prev_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        counter_d   = counter_q;
        ovf_d       = ovf_q;
        gate_lat_d  = gate_lat_q;
        count_out_d = count_out_q;
        gate_tag_d  = gate_tag_q;
        overflow_d  = overflow_q;
        bcd_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || single) state_d = S_ARM;
            end
            S_ARM: begin
                counter_d  = '0;
                ovf_d      = 1'b0;
                gate_lat_d = gate_sel;
                timer_d    = gate_len(gate_sel) - 32'd1;
                state_d    = S_GATE;
            end
            S_GATE: begin
                if (edge_det) begin
                    if (counter_q >= MAX_C) ovf_d = 1'b1;
                    else                    counter_d = counter_q + CNT_W'(1);
                end
                // The final gate cycle's edge is folded in before the result is latched,
                // so the outputs are already stable during the LATCH/bcd_start cycle.
                if (timer_q == 32'd0) begin
                    count_out_d = counter_d;
                    overflow_d  = ovf_d;
                    gate_tag_d  = gate_lat_q;
                    bcd_start_d = 1'b1;
                    state_d     = S_LATCH;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_LATCH: state_d = S_CONV;
            S_CONV: begin
                if (bcd_done) begin
                    timer_d = HOLD_LOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (timer_q == 32'd0) state_d = run ? S_ARM : S_IDLE;
                else                  timer_d = timer_q - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            counter_q   <= '0;
            ovf_q       <= 1'b0;
            gate_lat_q  <= 2'b00;
            count_out_q <= '0;
            gate_tag_q  <= 2'b00;
            overflow_q  <= 1'b0;
            bcd_start_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            counter_q   <= counter_d;
            ovf_q       <= ovf_d;
            gate_lat_q  <= gate_lat_d;
            count_out_q <= count_out_d;
            gate_tag_q  <= gate_tag_d;
            overflow_q  <= overflow_d;
            bcd_start_q <= bcd_start_d;
            sync1_q     <= signal_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
        end
    end

    assign bcd_start = bcd_start_q;
    assign count_out = count_out_q;
    assign gate_tag  = gate_tag_q;
    assign overflow  = overflow_q;
    assign valid     = (state_q == S_CONV) && bcd_done;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl: a default instance and a MAX_COUNT=50 instance,
// results checked against an expected queue as each bcd_start appears.
module tb_freq_meas_ctrl;

  typedef struct packed {
    logic [31:0] cnt;
    logic [1:0]  tol;
    logic [1:0]  tag;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig = 1'b0;
  logic        run_a = 1'b0, single_a = 1'b0, single_b = 1'b0, run_b = 1'b0;
  logic [1:0]  gate_sel = 2'b00;
  logic        bcd_done_m = 1'b0, bcd_done_tb = 1'b0, bcd_done_b = 1'b0;
  logic        bcd_start_a, overflow_a, valid_a, busy_a;
  logic        bcd_start_b, overflow_b, valid_b, busy_b;
  logic [31:0] count_out_a, count_out_b;
  logic [1:0]  gate_tag_a, gate_tag_b;

  exp_t        exp_q[$];
  exp_t        exp_b_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, half = 5;
  int          n_start_a = 0, n_start_b = 0, n_valid_a = 0;
  int          start_cyc_a = 0;
  logic [31:0] cnt_at_start_a = '0;

  freq_meas_ctrl #(.CLK_HZ(1000), .CNT_W(32), .MAX_COUNT(999_999), .HOLD_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .signal_in(sig), .run(run_a), .single(single_a),
    .gate_sel(gate_sel), .bcd_done(bcd_done_m | bcd_done_tb), .bcd_start(bcd_start_a),
    .count_out(count_out_a), .gate_tag(gate_tag_a), .overflow(overflow_a),
    .valid(valid_a), .busy(busy_a)
  );

  freq_meas_ctrl #(.CLK_HZ(1000), .CNT_W(32), .MAX_COUNT(50), .HOLD_CYCLES(20)) dut_sat (
    .clk(clk), .rst(rst), .signal_in(sig), .run(run_b), .single(single_b),
    .gate_sel(gate_sel), .bcd_done(bcd_done_b), .bcd_start(bcd_start_b),
    .count_out(count_out_b), .gate_tag(gate_tag_b), .overflow(overflow_b),
    .valid(valid_b), .busy(busy_b)
  );

  // clock / cycle counter
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // input signal: toggles every `half` cycles
  initial forever begin
    repeat (half) @(posedge clk);
    #1 sig = ~sig;
  end

  // BCD converter models: bcd_done five cycles after bcd_start
  initial forever begin
    @(negedge clk);
    if (bcd_start_a) begin
      repeat (5) @(posedge clk);
      #1 bcd_done_m = 1'b1;
      @(posedge clk);
      #1 bcd_done_m = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (bcd_start_b) begin
      repeat (5) @(posedge clk);
      #1 bcd_done_b = 1'b1;
      @(posedge clk);
      #1 bcd_done_b = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [31:0] obs, input exp_t e);
    checks++;
    assert ((obs + e.tol >= e.cnt) && (obs <= e.cnt + e.tol)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, e.cnt, e.tol);
    end
  endtask

  // scoreboard: pop one expected result per bcd_start
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bcd_start_a) begin
      n_start_a++;
      start_cyc_a    = cyc;
      cnt_at_start_a = count_out_a;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexp_start_a observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_rng("count_a", count_out_a, e);
        check("tag_a", 32'(gate_tag_a), 32'(e.tag));
        check("ovf_a", 32'(overflow_a), 32'(e.ovf));
      end
    end
    if (valid_a) begin
      n_valid_a++;
      check("valid_lat_a", cyc - start_cyc_a, 5);
      check("cnt_stable_a", count_out_a, cnt_at_start_a);
    end
    if (bcd_start_b) begin
      n_start_b++;
      checks++;
      assert (exp_b_q.size() > 0) else begin
        failures++;
        $error("FAIL unexp_start_b observed=1 expected=0");
      end
      if (exp_b_q.size() > 0) begin
        e = exp_b_q.pop_front();
        check_rng("count_b", count_out_b, e);
        check("ovf_b", 32'(overflow_b), 32'(e.ovf));
      end
    end
  end

  task automatic wait_starts_a(input int target, input int budget);
    int n = 0;
    while (n_start_a < target && n < budget) begin @(negedge clk); n++; end
    check("tmo_start_a", 32'(n_start_a >= target), 1);
  endtask

  task automatic wait_starts_b(input int target, input int budget);
    int n = 0;
    while (n_start_b < target && n < budget) begin @(negedge clk); n++; end
    check("tmo_start_b", 32'(n_start_b >= target), 1);
  endtask

  task automatic wait_idle(input bit sel_b, input int budget);
    int n = 0;
    while ((sel_b ? busy_b : busy_a) !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    check(sel_b ? "tmo_idle_b" : "tmo_idle_a", 32'(sel_b ? busy_b : busy_a), 0);
  endtask

  task automatic pulse_single(input bit sel_b);
    @(posedge clk);
    #1;
    if (sel_b) single_b = 1'b1; else single_a = 1'b1;
    @(posedge clk);
    #1 single_a = 1'b0;
    single_b = 1'b0;
  endtask

  initial begin
    int t0, base, idle_cnt, n;

    // reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", count_out_a, 0);
    check("rst_tag", 32'(gate_tag_a), 0);
    check("rst_ovf", 32'(overflow_a), 0);
    check("rst_start", 32'(bcd_start_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    idle_cnt = 0;
    repeat (2000) begin @(negedge clk); if (busy_a) idle_cnt++; end
    check("idle_busy", idle_cnt, 0);
    check("idle_starts", n_start_a, 0);

    // single shot, 1 s gate, period 10
    exp_q.push_back('{cnt: 100, tol: 1, tag: 2'b00, ovf: 1'b0});
    @(posedge clk);
    #1 single_a = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 single_a = 1'b0;
    @(negedge clk);
    check("busy_rise", 32'(busy_a), 1);
    wait_starts_a(1, 1100);
    check("start_latency", start_cyc_a - t0, 1002);
    n = 0;
    while (!valid_a && n < 20) begin @(negedge clk); n++; end
    check("valid_seen", 32'(valid_a), 1);
    repeat (20) @(negedge clk);
    check("hold_busy", 32'(busy_a), 1);
    @(negedge clk);
    check("hold_done", 32'(busy_a), 0);

    // continuous run, 100 ms gate, period 4
    half = 2;
    gate_sel = 2'b01;
    for (int i = 0; i < 3; i++) exp_q.push_back('{cnt: 25, tol: 1, tag: 2'b01, ovf: 1'b0});
    base = n_start_a;
    @(posedge clk);
    #1 run_a = 1'b1;
    repeat (2) @(negedge clk);
    idle_cnt = 0;
    n = 0;
    while (n_start_a < base + 3 && n < 600) begin
      @(negedge clk);
      n++;
      if (!busy_a) idle_cnt++;
    end
    run_a = 1'b0;
    check("run_starts", n_start_a - base, 3);
    check("run_no_idle", idle_cnt, 0);
    wait_idle(1'b0, 200);

    // gate_sel change mid-gate applies only to the next measurement
    half = 1;
    gate_sel = 2'b00;
    exp_q.push_back('{cnt: 500, tol: 1, tag: 2'b00, ovf: 1'b0});
    exp_q.push_back('{cnt: 5,   tol: 1, tag: 2'b10, ovf: 1'b0});
    base = n_start_a;
    @(posedge clk);
    #1 run_a = 1'b1;
    repeat (300) @(posedge clk);
    #1 gate_sel = 2'b10;
    wait_starts_a(base + 2, 1200);
    run_a = 1'b0;
    wait_idle(1'b0, 200);

    // reset in the middle of a gate aborts without a result
    gate_sel = 2'b00;
    pulse_single(1'b0);
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_count", count_out_a, 0);
    base = n_start_a;
    repeat (1100) @(negedge clk);
    check("abort_no_start", n_start_a, base);

    // single during CONV is ignored
    gate_sel = 2'b10;
    exp_q.push_back('{cnt: 5, tol: 1, tag: 2'b10, ovf: 1'b0});
    pulse_single(1'b0);
    wait_starts_a(base + 1, 100);
    pulse_single(1'b0);
    wait_idle(1'b0, 100);
    idle_cnt = 0;
    repeat (100) begin @(negedge clk); if (busy_a) idle_cnt++; end
    check("conv_single_ignored", idle_cnt, 0);
    check("conv_single_starts", n_start_a, base + 1);

    // bcd_done while idle
    base = n_valid_a;
    @(posedge clk);
    #1 bcd_done_tb = 1'b1;
    @(negedge clk);
    check("idle_done_valid", 32'(valid_a), 0);
    @(posedge clk);
    #1 bcd_done_tb = 1'b0;
    check("idle_done_nvalid", n_valid_a, base);

    // saturation at MAX_COUNT=50, then a clean gate clears overflow
    half = 1;
    gate_sel = 2'b00;
    exp_b_q.push_back('{cnt: 50, tol: 0, tag: 2'b00, ovf: 1'b1});
    pulse_single(1'b1);
    wait_starts_b(1, 1100);
    wait_idle(1'b1, 100);
    half = 50;
    exp_b_q.push_back('{cnt: 10, tol: 1, tag: 2'b00, ovf: 1'b0});
    pulse_single(1'b1);
    wait_starts_b(2, 1100);
    wait_idle(1'b1, 100);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_b_q_empty", exp_b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Measurement sequencer for the frequency counter.
- Owns the gate timer and the input edge counter.
- Drives a start/done handshake to the downstream sequential binary-to-BCD converter.
- Holds each result for a display period, then re-arms (continuous mode) or stops (single-shot mode).
- Sits between the raw input pin and the BCD converter / 7-segment decoders.

Parameters:
- CLK_HZ, 50_000_000, clk frequency in Hz; gate lengths derive from it.
- CNT_W, 32, width of the edge counter and count_out.
- MAX_COUNT, 999_999, saturation limit (6 display digits).
- HOLD_CYCLES, 25_000_000, result hold time after conversion (0.5 s at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- signal_in  in  1  asynchronous signal under measurement
- run  in  1  level; continuous measurement while high
- single  in  1  one-cycle request for one measurement
- gate_sel  in  2  gate time: 00=1 s, 01=100 ms, 10=10 ms, 11=10 s
- bcd_done  in  1  one-cycle pulse from the BCD converter when its output is valid
- bcd_start  out  1  one-cycle pulse; count_out is stable and ready to convert
- count_out  out  CNT_W  latched edge count of the last gate
- gate_tag  out  2  gate_sel value used for count_out; sets the decimal-point position
- overflow  out  1  last gate hit MAX_COUNT
- valid  out  1  one-cycle pulse when bcd_done is accepted
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: count_out=0, gate_tag=00, overflow=0, bcd_start=0, valid=0, busy=0. Synchronizer and prev flops are 0, state is IDLE. Reset mid-operation aborts immediately and no bcd_start is issued.
- Input path: 2-FF synchronizer, then a prev register. An edge is sync2=1 and prev=0, giving 3 cycles of pin-to-edge latency. Edges count only in GATE.
- Gate length G in cycles: 1 s = CLK_HZ; 100 ms = CLK_HZ/10; 10 ms = CLK_HZ/100; 10 s = CLK_HZ*10. The timer is 32 bits; CLK_HZ*10 must fit in 32 bits.
- IDLE:
  - run=1 or single=1 -> ARM.
  - single while busy=1 is ignored (no queuing).
- ARM (1 cycle):
  - clear the edge counter;
  - latch gate_sel into an internal register;
  - load timer=G-1;
  - -> GATE.
- GATE (exactly G cycles):
  - increment the edge counter per edge, saturating at MAX_COUNT;
  - set an internal ovf flag on an edge seen while the counter is already MAX_COUNT;
  - timer decrements each cycle; GATE ends after the cycle with timer==0, whose edge is counted;
  - -> LATCH.
- LATCH (1 cycle):
  - count_out<=counter, overflow<=ovf, gate_tag<=latched gate_sel;
  - bcd_start=1 this cycle; edges in this cycle are discarded;
  - -> CONV.
- CONV: wait for bcd_done. On bcd_done, valid=1 for the same cycle -> HOLD. No timeout.
- HOLD: count HOLD_CYCLES cycles. Then run=1 -> ARM, else -> IDLE.
- Output stability: count_out, gate_tag and overflow change only in LATCH. They are stable from bcd_start until the next LATCH.
- gate_sel changes after ARM do not affect the current gate.
- run dropping mid-measurement: the current cycle completes through HOLD, then -> IDLE.
- bcd_done outside CONV is ignored and valid stays 0.
- Simultaneous single and run in IDLE: one ARM, then behaviour follows run.
- Throughput: one result per G+3+conversion+HOLD_CYCLES cycles.

Test Plan:
All scenarios use CLK_HZ=1000, HOLD_CYCLES=20, MAX_COUNT=999_999, and a BCD model returning bcd_done 5 cycles after bcd_start.
- Reset then idle: rst=1 for 3 cycles, run=0 -> all outputs 0, busy=0, no bcd_start for 2000 cycles.
- single pulse, gate_sel=00, signal period 10 cycles -> busy rises next cycle. bcd_start after 1002 cycles (ARM+GATE+LATCH). count_out=100±1, gate_tag=00, valid 5 cycles later, busy=0 after HOLD.
- run=1, gate_sel=01 (G=100), period 4 -> back-to-back results with count_out=25±1 each. The sequence repeats without returning to IDLE.
- gate_sel switched from 00 to 10 mid-gate -> current result uses G=1000 with gate_tag=00. The next result uses G=10 with gate_tag=10.
- MAX_COUNT override=50, period 2, G=1000 -> count_out=50, overflow=1. The next gate with period 100 gives overflow=0, count_out=10.
- rst mid-GATE -> no bcd_start, count_out keeps 0, state IDLE. single during CONV ignored; bcd_done in IDLE -> valid stays 0.
